// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB2APB bridge: APB master FSM states,
// AHB response codes and the APB slave address map.
package ahb_apb_pkg;

  localparam int unsigned MAP_ADDR_W = 32;
  localparam int unsigned MAP_NSEL   = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    ERR1   = 3'd3,
    ERR2   = 3'd4
  } apb_state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [MAP_ADDR_W-1:0] SLV0_BASE = 32'h8000_0000;
  localparam logic [MAP_ADDR_W-1:0] SLV1_BASE = 32'h8400_0000;
  localparam logic [MAP_ADDR_W-1:0] SLV2_BASE = 32'h8800_0000;
  localparam logic [MAP_ADDR_W-1:0] SLV_LIMIT = 32'h8C00_0000;

  // One-hot slave select for an address; zero when outside the APB window.
  function automatic logic [MAP_NSEL-1:0] decode_sel(input logic [MAP_ADDR_W-1:0] addr);
    logic [MAP_NSEL-1:0] sel;
    sel = '0;
    if (addr >= SLV0_BASE && addr < SLV1_BASE)      sel = 3'b001;
    else if (addr >= SLV1_BASE && addr < SLV2_BASE) sel = 3'b010;
    else if (addr >= SLV2_BASE && addr < SLV_LIMIT) sel = 3'b100;
    return sel;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-phase wait-state counter; expired flags the last
// allowed wait cycle so the FSM can abort a hung slave.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic Hclk,
  input  logic Hresetn,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != CNT_W'(CNT_MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // A zero timeout parameter disables the abort path entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master_controller.sv
// APB3 master for the AHB2APB bridge: turns a latched AHB request into a
// SETUP/ACCESS transfer and returns the AHB-side ready/data/response.
module apb_master_controller
  import ahb_apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned NSEL           = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_write,
  input  logic [NSEL-1:0]   req_sel,
  input  logic              buffer_full,
  output logic              bridge_ready,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Pwrite,
  output logic [NSEL-1:0]   Pselx,
  output logic              Penable,
  input  logic              Pready,
  input  logic              Pslverr,
  input  logic [DATA_W-1:0] Prdata,
  output logic              Hreadyout,
  output logic [DATA_W-1:0] Hrdata,
  output logic              Hresp
);

  apb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [NSEL-1:0]   pselx_q, pselx_d;
  logic              penable_q, penable_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic              hresp_q, hresp_d;
  logic              timer_clear, timer_en, timer_expired;

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    pselx_d   = pselx_q;
    penable_d = penable_q;
    hrdata_d  = hrdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && (req_sel != '0)) begin
          state_d   = SETUP;
          paddr_d   = req_addr;
          pwdata_d  = req_wdata;
          pwrite_d  = req_write;
          pselx_d   = req_sel;
          penable_d = 1'b0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (Pready) begin
          pselx_d   = '0;
          penable_d = 1'b0;
          if (Pslverr) begin
            state_d = ERR1;
          end else begin
            state_d = IDLE;
            if (!pwrite_q) hrdata_d = Prdata;
          end
        end else if (timer_expired) begin
          state_d   = ERR1;
          pselx_d   = '0;
          penable_d = 1'b0;
        end
      end
      ERR1:    state_d = ERR2;
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    hresp_d = ((state_d == ERR1) || (state_d == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      pselx_q   <= '0;
      penable_q <= 1'b0;
      hrdata_q  <= '0;
      hresp_q   <= HRESP_OKAY;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      pselx_q   <= pselx_d;
      penable_q <= penable_d;
      hrdata_q  <= hrdata_d;
      hresp_q   <= hresp_d;
    end
  end

  // Counter runs only while waiting in ACCESS and is zeroed on every exit.
  assign timer_en    = (state_q == ACCESS) && !Pready;
  assign timer_clear = (state_q != ACCESS) || (state_d != ACCESS);

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .clear   (timer_clear),
    .count_en(timer_en),
    .expired (timer_expired)
  );

  assign bridge_ready = (state_q == IDLE);
  assign Hreadyout    = !(buffer_full
                          || (!pwrite_q && ((state_q == SETUP) || (state_q == ACCESS)))
                          || (state_q == ERR1));
  assign Paddr   = paddr_q;
  assign Pwdata  = pwdata_q;
  assign Pwrite  = pwrite_q;
  assign Pselx   = pselx_q;
  assign Penable = penable_q;
  assign Hrdata  = hrdata_q;
  assign Hresp   = hresp_q;

  // Upstream gates req_valid with bridge_ready, so a request outside IDLE is a protocol bug.
  a_req_only_in_idle: assert property (@(posedge Hclk) disable iff (!Hresetn)
    req_valid |-> (state_q == IDLE));

endmodule

// File: tb/tb_apb_master_controller.sv
// Directed self-checking bench for apb_master_controller (timeout set to 4).
module tb_apb_master_controller;

  logic        Hclk, Hresetn;
  logic        req_valid, req_write, buffer_full;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_sel;
  logic        bridge_ready, Pwrite, Penable, Pready, Pslverr, Hreadyout, Hresp;
  logic [31:0] Paddr, Pwdata, Prdata, Hrdata;
  logic [2:0]  Pselx;

  int total = 0;
  int bad   = 0;

  apb_master_controller #(
    .ADDR_W(32), .DATA_W(32), .NSEL(3), .TIMEOUT_CYCLES(4)
  ) dut (
    .Hclk(Hclk), .Hresetn(Hresetn),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_write(req_write), .req_sel(req_sel), .buffer_full(buffer_full),
    .bridge_ready(bridge_ready),
    .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable),
    .Pready(Pready), .Pslverr(Pslverr), .Prdata(Prdata),
    .Hreadyout(Hreadyout), .Hrdata(Hrdata), .Hresp(Hresp)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [2:0] s);
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_write = w; req_sel = s;
    tick();
    req_valid = 1'b0;
  endtask

  logic [31:0] bb_addr [3];
  logic [31:0] bb_data [3];
  logic [2:0]  bb_sel  [3];

  initial begin
    Hresetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
    req_sel = '0; buffer_full = 1'b0; Pready = 1'b1; Pslverr = 1'b0; Prdata = '0;
    bb_addr[0] = 32'h8000_0100; bb_data[0] = 32'hA0A0_0001; bb_sel[0] = 3'b001;
    bb_addr[1] = 32'h8400_0200; bb_data[1] = 32'hB0B0_0002; bb_sel[1] = 3'b010;
    bb_addr[2] = 32'h8800_0300; bb_data[2] = 32'hC0C0_0003; bb_sel[2] = 3'b100;

    // reset state
    #12;
    chk("rst_paddr", Paddr, 32'h0);
    chk("rst_pselx", 32'(Pselx), 32'h0);
    chk("rst_penable", 32'(Penable), 32'h0);
    chk("rst_pwrite", 32'(Pwrite), 32'h0);
    chk("rst_hresp", 32'(Hresp), 32'h0);
    chk("rst_hrdata", Hrdata, 32'h0);
    Hresetn = 1'b1;
    tick();
    chk("rst_bridge_ready", 32'(bridge_ready), 32'h1);
    chk("rst_hreadyout", 32'(Hreadyout), 32'h1);

    // single write
    issue(32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 3'b001);
    chk("wr_setup_pselx", 32'(Pselx), 32'h1);
    chk("wr_setup_penable", 32'(Penable), 32'h0);
    chk("wr_setup_paddr", Paddr, 32'h8000_0010);
    chk("wr_setup_pwdata", Pwdata, 32'hDEAD_BEEF);
    chk("wr_setup_pwrite", 32'(Pwrite), 32'h1);
    chk("wr_setup_ready", 32'(bridge_ready), 32'h0);
    chk("wr_setup_hreadyout", 32'(Hreadyout), 32'h1);
    tick();
    chk("wr_access_penable", 32'(Penable), 32'h1);
    chk("wr_access_pselx", 32'(Pselx), 32'h1);
    chk("wr_access_hresp", 32'(Hresp), 32'h0);
    tick();
    chk("wr_done_ready", 32'(bridge_ready), 32'h1);
    chk("wr_done_pselx", 32'(Pselx), 32'h0);
    chk("wr_done_penable", 32'(Penable), 32'h0);
    chk("wr_done_hresp", 32'(Hresp), 32'h0);

    // read with two wait states
    Pready = 1'b0;
    issue(32'h8400_0004, 32'h0, 1'b0, 3'b010);
    chk("rd_setup_pselx", 32'(Pselx), 32'h2);
    chk("rd_setup_hreadyout", 32'(Hreadyout), 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rd_wait_penable", 32'(Penable), 32'h1);
      chk("rd_wait_hreadyout", 32'(Hreadyout), 32'h0);
      chk("rd_wait_paddr", Paddr, 32'h8400_0004);
      chk("rd_wait_hrdata", Hrdata, 32'h0);
    end
    tick();
    Pready = 1'b1; Prdata = 32'h1234_5678;
    #1;
    chk("rd_last_hreadyout", 32'(Hreadyout), 32'h0);
    chk("rd_last_penable", 32'(Penable), 32'h1);
    tick();
    Prdata = 32'hFFFF_0000;
    chk("rd_done_hrdata", Hrdata, 32'h1234_5678);
    chk("rd_done_hreadyout", 32'(Hreadyout), 32'h1);
    chk("rd_done_ready", 32'(bridge_ready), 32'h1);
    chk("rd_done_penable", 32'(Penable), 32'h0);

    // slave error
    Pslverr = 1'b1;
    issue(32'h8800_0000, 32'h5555_AAAA, 1'b1, 3'b100);
    chk("err_setup_pselx", 32'(Pselx), 32'h4);
    tick();
    chk("err_access_penable", 32'(Penable), 32'h1);
    tick();
    Pslverr = 1'b0;
    chk("err1_hresp", 32'(Hresp), 32'h1);
    chk("err1_hreadyout", 32'(Hreadyout), 32'h0);
    chk("err1_pselx", 32'(Pselx), 32'h0);
    chk("err1_ready", 32'(bridge_ready), 32'h0);
    tick();
    chk("err2_hresp", 32'(Hresp), 32'h1);
    chk("err2_hreadyout", 32'(Hreadyout), 32'h1);
    tick();
    chk("err_idle_hresp", 32'(Hresp), 32'h0);
    chk("err_idle_ready", 32'(bridge_ready), 32'h1);
    chk("err_hrdata_hold", Hrdata, 32'h1234_5678);

    // timeout twice: second run shows the counter restarted from zero
    Pready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      issue(32'h8000_0020, 32'h0000_0042, (t == 0), 3'b001);
      tick();
      for (int c = 1; c < 4; c++) begin
        chk("to_access_penable", 32'(Penable), 32'h1);
        tick();
      end
      chk("to_access4_penable", 32'(Penable), 32'h1);
      chk("to_access4_hresp", 32'(Hresp), 32'h0);
      chk("to_access4_hreadyout", 32'(Hreadyout), (t == 0) ? 32'h1 : 32'h0);
      tick();
      chk("to_err1_hresp", 32'(Hresp), 32'h1);
      chk("to_err1_pselx", 32'(Pselx), 32'h0);
      chk("to_err1_penable", 32'(Penable), 32'h0);
      chk("to_err1_hreadyout", 32'(Hreadyout), 32'h0);
      tick();
      chk("to_err2_hresp", 32'(Hresp), 32'h1);
      tick();
      chk("to_idle_ready", 32'(bridge_ready), 32'h1);
    end
    chk("to_hrdata_hold", Hrdata, 32'h1234_5678);
    Pready = 1'b1;

    // req_sel of zero is ignored
    issue(32'h8000_0040, 32'h1, 1'b1, 3'b000);
    chk("sel0_ready", 32'(bridge_ready), 32'h1);
    chk("sel0_pselx", 32'(Pselx), 32'h0);

    // back-to-back writes, buffer_full pulsed during the second SETUP
    for (int i = 0; i < 3; i++) begin
      chk("bb_ready", 32'(bridge_ready), 32'h1);
      issue(bb_addr[i], bb_data[i], 1'b1, bb_sel[i]);
      buffer_full = (i == 1);
      #1;
      chk("bb_setup_pselx", 32'(Pselx), 32'(bb_sel[i]));
      chk("bb_setup_paddr", Paddr, bb_addr[i]);
      chk("bb_hreadyout", 32'(Hreadyout), (i == 1) ? 32'h0 : 32'h1);
      buffer_full = 1'b0;
      tick();
      chk("bb_access_penable", 32'(Penable), 32'h1);
      chk("bb_access_pwdata", Pwdata, bb_data[i]);
      tick();
    end
    chk("bb_end_ready", 32'(bridge_ready), 32'h1);

    // reset while in ACCESS
    Pready = 1'b0;
    issue(32'h8000_0050, 32'h7777_7777, 1'b1, 3'b001);
    tick();
    chk("rstacc_penable_pre", 32'(Penable), 32'h1);
    Hresetn = 1'b0;
    #1;
    chk("rstacc_pselx", 32'(Pselx), 32'h0);
    chk("rstacc_penable", 32'(Penable), 32'h0);
    chk("rstacc_hrdata", Hrdata, 32'h0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    Pready = 1'b1;
    tick();
    chk("rstacc_ready", 32'(bridge_ready), 32'h1);
    chk("rstacc_hresp", 32'(Hresp), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
